// File: rtl/alu_pipe.sv
// Pipelined two-operand ADD/AND/OR/XOR unit with valid/ready on both sides.
// Optional output-transfer counter (txn_cnt) is built only when ALU_PIPE_CNT_EN is defined.
module alu_pipe #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   y
`ifdef ALU_PIPE_CNT_EN
    ,
    output logic [CNT_W-1:0] txn_cnt
`endif
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    logic [WIDTH:0]              alu_res;
    logic [STAGES:1]             rdy;
    logic                        rdy_acc;
    logic [STAGES:1]             vld_q, vld_d;
    logic [STAGES:1][WIDTH:0]    data_q, data_d;

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = {1'b0, a} + {1'b0, b};
            OP_AND:  alu_res = {1'b0, a & b};
            OP_OR:   alu_res = {1'b0, a | b};
            OP_XOR:  alu_res = {1'b0, a ^ b};
            default: alu_res = '0;
        endcase
    end

    // Ready chain unrolled from the output side: a stage can load if it or
    // any stage downstream of it is empty, or the consumer is taking a result.
    always_comb begin
        rdy     = '0;
        rdy_acc = out_ready;
        for (int k = STAGES; k >= 1; k--) begin
            rdy_acc = rdy_acc || !vld_q[k];
            rdy[k]  = rdy_acc;
        end
    end

    // Data only moves when a valid beat moves, so y holds its last value
    // while the pipeline drains.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (rdy[1]) begin
            vld_d[1] = in_valid;
            if (in_valid) begin
                data_d[1] = alu_res;
            end
        end
        for (int k = 2; k <= STAGES; k++) begin
            if (rdy[k]) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign in_ready  = rdy[1];
    assign out_valid = vld_q[STAGES];
    assign y         = data_q[STAGES];

`ifdef ALU_PIPE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign txn_cnt = cnt_q;
`endif

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined two-operand arithmetic/logic unit with a valid/ready handshake on both sides. It generalises the team's combinational 4-bit adder and 4-bit AND blocks into one unit with configurable operand width, selectable operation and a configurable number of register stages. It sits between an operand source and a result consumer, either of which may stall, and neither drops nor reorders results.

## Interface
- `WIDTH`, 4: operand width in bits; must be ≥ 1.
- `STAGES`, 2: number of pipeline register stages; must be ≥ 1.
- `CNT_W`, 16: width of the optional transaction counter.

- `clk` input 1: sole clock; rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: the operand beat on `a`, `b`, `op` is valid.
- `in_ready` output 1: the block accepts a beat this cycle.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `op` input 2: operation select: 00 ADD, 01 AND, 10 OR, 11 XOR.
- `out_valid` output 1: `y` holds a valid result.
- `out_ready` input 1: the consumer accepts the result this cycle.
- `y` output WIDTH+1: result.
- `txn_cnt` output CNT_W: count of completed output transfers. Present only under `ALU_PIPE_CNT_EN`.

## Operation
- A beat is accepted when `in_valid && in_ready` at a rising edge.
- A result is transferred when `out_valid && out_ready` at a rising edge.
- ADD: `y = {1'b0,a} + {1'b0,b}`. This is a full WIDTH+1 sum; the carry-out lands in the MSB and the sum never wraps.
- AND, OR and XOR: `y[WIDTH-1:0] = a op b`, with `y[WIDTH] = 0`.
- The result is computed combinationally in front of stage 1. Stages 2..STAGES carry it forward unchanged.
- Each stage k holds a data register and a `vld[k]`. Stage STAGES drives `y` and `out_valid`.
- Per-stage ready: `rdy[STAGES] = !vld[STAGES] || out_ready` and `rdy[k] = !vld[k] || rdy[k+1]`.
- `in_ready = rdy[1]`. The path is combinational from `out_ready` through the chain. There is no skid buffer.
- A stage loads from its predecessor when `rdy[k]` is high. Its `vld[k]` then takes the predecessor's valid (`in_valid` for stage 1).
- A stalled stage holds its data and valid unchanged.
- Results leave in acceptance order. There is no loss and no duplication.
- The block holds at most STAGES beats in flight.
- `y` is don't-care while `out_valid = 0`, but is implemented as holding its last value.

## Timing
- Reset: all `vld = 0` and all data registers = 0, so `out_valid = 0` and `y = 0`. `in_ready = 1` immediately after reset, because all stages are empty. `txn_cnt = 0`.
- Latency: a beat accepted at edge N appears with `out_valid = 1` after edge N+STAGES-1, i.e. it is visible in cycle N+STAGES-1. This holds when there is no stall.
- Throughput: one beat per cycle while `out_ready` is held high.
- Full with `out_ready = 1`: `in_ready = 1` in the same cycle, and a simultaneous accept and transfer occur with no bubble.
- Full with `out_ready = 0`: `in_ready = 0`, and all stages hold.
- Partially full and stalled: bubbles collapse. Empty stages keep accepting until the pipeline is full.
- `out_valid` must not drop, and `y` must not change, while `out_valid && !out_ready`.
- Reset asserted mid-operation: all in-flight beats are discarded asynchronously and outputs return to their reset values. No result emerges after reset deasserts.
- `op`, `a` and `b` are sampled only at an accepting edge.

## Configuration
- `ALU_PIPE_CNT_EN` defined:
  - `txn_cnt` is present.
  - It increments by 1 on each output transfer and wraps from 2^CNT_W−1 to 0.
  - It resets to 0.
- `ALU_PIPE_CNT_EN` not defined:
  - The port and the counter logic are absent.
  - Datapath behaviour is identical.

## Test plan
- ADD, STAGES=2, `out_ready = 1`: drive a=4, b=4, then a=3, b=4, then a=3, b=7. Expect `y` = 8, 7, 10 on consecutive cycles, each 2 cycles after its accept.
- Carry and logic ops, WIDTH=4: 15+1 → `y = 5'b10000`; AND 0100 & 1100 → `5'b00100`; OR 0011 | 1100 → `5'b01111`; XOR 1111 ^ 1010 → `5'b00101`.
- Backpressure: stream 6 beats with `out_ready` low for 5 cycles. Expect `in_ready` low after STAGES accepts, then all 6 results in order with no loss or duplicates, and `y` stable while stalled.
- Simultaneous events: pipeline full, `out_ready` and `in_valid` both high. Expect a transfer and an accept in the same cycle, and sustained 1 beat per cycle.
- Reset mid-flight: 2 beats in flight, pulse `rst_n` low asynchronously between edges. Expect `out_valid = 0` and `y = 0` immediately, no stale result after release, and `in_ready = 1`.
- With `ALU_PIPE_CNT_EN` and CNT_W=3: 9 transfers → `txn_cnt = 1` (wrapped). Transfers held back by a stall are not counted until they complete.
